// File: rtl/ifu_pkg.sv
// Shared constants and types for the fetch-queue IFU.
// The widths here describe the default configuration (XLEN=32,
// IMEM_DEPTH=256, FQ_DEPTH=4). Parametrised instances derive their own widths.
package ifu_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int IMEM_DEPTH_DEF = 256;
  localparam int FQ_DEPTH_DEF   = 4;

  localparam int IMEM_AW = $clog2(IMEM_DEPTH_DEF);
  localparam int FQ_AW   = $clog2(FQ_DEPTH_DEF);

  // Sequential fetch advances by one 32-bit instruction word.
  localparam int PC_STEP = 4;

  // Queue entry at the default width. The PC sits in the upper half.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Generic circular FIFO with synchronous flush, push, pop, count and head.
// Flush wins over push and pop on the same edge. A pop while empty is ignored.
// A push while full is ignored unless a pop frees a slot on the same edge.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   head_valid_o,
  output logic [WIDTH-1:0]       head_data_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  // Next-state pointers and occupancy. Pointers wrap naturally at a power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage. Flushed slots are left stale because the count gates them.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch unit: PC, synchronous-read instruction memory, and credit-based issue
// into a fetch queue that decode drains with valid/ready.
// A taken branch redirects the PC and flushes the queue and the in-flight read.
// Optional macro IFU_MISALIGN_EN: a misaligned redirect sets a sticky flag
// and freezes issue until an aligned redirect or a reset.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 256,
  parameter int              FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [XLEN-1:0]           branch_target,
  input  logic                      branch_taken,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [XLEN-1:0]           out_instr,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           pc,
  output logic [$clog2(FQ_DEPTH):0] fq_count,
  output logic                      fetch_misaligned
);
  localparam int MEM_AW = $clog2(IMEM_DEPTH);
  localparam int CNT_W  = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  // Preloaded through the hierarchy. There is no write port.
  logic [XLEN-1:0] instruction_memory [0:IMEM_DEPTH-1];

  logic [XLEN-1:0] pc_q, pc_d;
  logic            rd_valid_q, rd_valid_d;
  logic [XLEN-1:0] rd_data_q, rd_pc_q;
  logic            misalign_q;
  logic            credit_ok, issue;
  logic [CNT_W-1:0] count;
  entry_t          head;
  logic            head_valid;

  // Credit covers both queued entries and the read still in flight, so a push never overflows.
  assign credit_ok = (count + CNT_W'(rd_valid_q)) < CNT_W'(FQ_DEPTH);
  assign issue     = !branch_taken && !misalign_q && credit_ok;

`ifdef IFU_MISALIGN_EN
  logic misalign_d;

  // PC / read-valid / misalign next state. A redirect overrides issue.
  always_comb begin
    pc_d       = pc_q;
    rd_valid_d = 1'b0;
    misalign_d = misalign_q;
    if (branch_taken) begin
      pc_d       = branch_target;
      misalign_d = (branch_target[1:0] != 2'b00);
    end else if (issue) begin
      pc_d       = pc_q + XLEN'(PC_STEP);
      rd_valid_d = 1'b1;
    end
  end

  // Sticky misalign flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`else
  // PC / read-valid next state. Redirect targets are forced to word alignment.
  always_comb begin
    pc_d       = pc_q;
    rd_valid_d = 1'b0;
    if (branch_taken) begin
      pc_d = branch_target & ~XLEN'(3);
    end else if (issue) begin
      pc_d       = pc_q + XLEN'(PC_STEP);
      rd_valid_d = 1'b1;
    end
  end

  assign misalign_q = 1'b0;
`endif

  // PC and in-flight read valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      rd_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Synchronous memory read. Upper PC bits are dropped, so addresses alias.
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_data_q <= instruction_memory[pc_q[MEM_AW+1:2]];
      rd_pc_q   <= pc_q;
    end
  end

  ifu_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (reset),
    .flush_i      (branch_taken),
    .push_i       (rd_valid_q),
    .push_data_i  ({rd_pc_q, rd_data_q}),
    .pop_i        (out_ready),
    .count_o      (count),
    .head_valid_o (head_valid),
    .head_data_o  (head)
  );

  assign out_valid        = head_valid;
  assign out_pc           = head_valid ? head.pc    : '0;
  assign out_instr        = head_valid ? head.instr : '0;
  assign pc               = pc_q;
  assign fq_count         = count;
  assign fetch_misaligned = misalign_q;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue. dut_a uses the default configuration.
// dut_b uses a 16-word memory and a reset PC just below 2^32 to exercise
// address wrap and aliasing. Inputs change 1 time unit after a rising edge,
// and outputs are sampled at that same point.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default-configuration DUT
  logic        rst_a, bt_a, rdy_a;
  logic [31:0] tgt_a;
  logic        ov_a, mis_a;
  logic [31:0] oi_a, opc_a, pc_a;
  logic [2:0]  cnt_a;

  // small-memory / wrapping-PC DUT
  logic        rst_b, bt_b, rdy_b;
  logic [31:0] tgt_b;
  logic        ov_b, mis_b;
  logic [31:0] oi_b, opc_b, pc_b;
  logic [2:0]  cnt_b;

  ifu_fetch_queue dut_a (
    .clk(clk), .reset(rst_a), .branch_target(tgt_a), .branch_taken(bt_a),
    .out_ready(rdy_a), .out_valid(ov_a), .out_instr(oi_a), .out_pc(opc_a),
    .pc(pc_a), .fq_count(cnt_a), .fetch_misaligned(mis_a)
  );

  ifu_fetch_queue #(.IMEM_DEPTH(16), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(rst_b), .branch_target(tgt_b), .branch_taken(bt_b),
    .out_ready(rdy_b), .out_valid(ov_b), .out_instr(oi_b), .out_pc(opc_b),
    .pc(pc_b), .fq_count(cnt_b), .fetch_misaligned(mis_b)
  );

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem_a [0:15];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head_a(input string tag, input logic [31:0] epc);
    check({tag, ".valid"}, 64'(ov_a), 64'd1);
    check({tag, ".pc"}, 64'(opc_a), 64'(epc));
    check({tag, ".instr"}, 64'(oi_a), 64'(mem_a[epc[5:2]]));
  endtask

  initial begin
    rst_a = 1'b1; bt_a = 1'b0; rdy_a = 1'b1; tgt_a = '0;
    rst_b = 1'b1; bt_b = 1'b0; rdy_b = 1'b1; tgt_b = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = (i < 12) ? 32'(i + 1) * 32'h1111_1111 : 32'hDEAD_0000 + 32'(i);
      dut_a.instruction_memory[i] = mem_a[i];
      dut_b.instruction_memory[i] = 32'hB000_0000 + 32'(i);
    end
    for (int i = 16; i < 256; i++) dut_a.instruction_memory[i] = 32'hDEAD_0000 + 32'(i);

    // reset state; out_ready is ignored while empty
    tick();
    check("rst.pc", 64'(pc_a), 64'h0);
    check("rst.valid", 64'(ov_a), 64'h0);
    check("rst.count", 64'(cnt_a), 64'h0);
    check("rst.pc_out", 64'(opc_a), 64'h0);
    check("rst.instr", 64'(oi_a), 64'h0);
    check("rst.mis", 64'(mis_a), 64'h0);

    // 1: sequential fetch, latency of 2 edges
    rst_a = 1'b0;
    tick();
    check("seq.e1_valid", 64'(ov_a), 64'h0);
    check("seq.e1_pc", 64'(pc_a), 64'h4);
    tick(); head_a("seq0", 32'h0);
    tick(); head_a("seq1", 32'h4);
    tick(); head_a("seq2", 32'h8);

    // reset in mid-run takes effect without a clock edge
    #2 rst_a = 1'b1;
    #1;
    check("midrst.count", 64'(cnt_a), 64'h0);
    check("midrst.valid", 64'(ov_a), 64'h0);
    check("midrst.pc", 64'(pc_a), 64'h0);

    // 2: backpressure fills to 4 entries with pc frozen at 0x10
    rdy_a = 1'b0;
    tick();
    rst_a = 1'b0;
    repeat (10) tick();
    check("bp.count", 64'(cnt_a), 64'd4);
    check("bp.pc", 64'(pc_a), 64'h10);
    head_a("bp.head", 32'h0);
    rdy_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      head_a($sformatf("drain%0d", k), 32'(4 * k));
      tick();
    end

    // 3: refill to 0x8..0x14, then redirect to 0x20
    rst_a = 1'b1; rdy_a = 1'b0;
    tick();
    rst_a = 1'b0;
    repeat (6) tick();
    rdy_a = 1'b1;
    tick(); tick();
    rdy_a = 1'b0;
    tick(); tick();
    check("fl.pre_count", 64'(cnt_a), 64'd4);
    check("fl.pre_pc", 64'(pc_a), 64'h18);
    head_a("fl.pre_head", 32'h8);
    bt_a = 1'b1; tgt_a = 32'h20;
    tick();
    check("fl.count", 64'(cnt_a), 64'h0);
    check("fl.valid", 64'(ov_a), 64'h0);
    check("fl.pc", 64'(pc_a), 64'h20);
    bt_a = 1'b0; rdy_a = 1'b1;
    tick();
    check("fl.e1_valid", 64'(ov_a), 64'h0);
    tick(); head_a("fl.t0", 32'h20);
    tick(); head_a("fl.t1", 32'h24);

    // 4: redirect on the same edge as a pop; the popped head is discarded
    bt_a = 1'b1; tgt_a = 32'h4;
    tick();
    check("rp.count", 64'(cnt_a), 64'h0);
    check("rp.valid", 64'(ov_a), 64'h0);
    check("rp.pc", 64'(pc_a), 64'h4);
    bt_a = 1'b0;
    tick();
    check("rp.e1_valid", 64'(ov_a), 64'h0);
    tick(); head_a("rp.t0", 32'h4);

    // 6: misaligned redirect
    bt_a = 1'b1; tgt_a = 32'h22;
    tick();
`ifdef IFU_MISALIGN_EN
    check("mis.flag", 64'(mis_a), 64'h1);
    check("mis.pc", 64'(pc_a), 64'h22);
    bt_a = 1'b0;
    repeat (3) tick();
    check("mis.frozen_valid", 64'(ov_a), 64'h0);
    check("mis.frozen_pc", 64'(pc_a), 64'h22);
    bt_a = 1'b1; tgt_a = 32'h24;
    tick();
    check("mis.clr", 64'(mis_a), 64'h0);
    check("mis.pc2", 64'(pc_a), 64'h24);
    bt_a = 1'b0;
    tick(); tick();
    head_a("mis.t0", 32'h24);
`else
    check("mis.flag", 64'(mis_a), 64'h0);
    check("mis.pc", 64'(pc_a), 64'h20);
    bt_a = 1'b0;
    tick(); tick();
    head_a("mis.t0", 32'h20);
`endif

    // 5: PC wrap from 0xFFFFFFFC and aliasing with a 16-word memory
    rst_b = 1'b0;
    tick();
    check("wr.pc", 64'(pc_b), 64'h0);
    check("wr.e1_valid", 64'(ov_b), 64'h0);
    tick();
    check("wr.h0_pc", 64'(opc_b), 64'hFFFF_FFFC);
    check("wr.h0_instr", 64'(oi_b), 64'hB000_000F);
    tick();
    check("wr.h1_pc", 64'(opc_b), 64'h0);
    check("wr.h1_instr", 64'(oi_b), 64'hB000_0000);
    bt_b = 1'b1; tgt_b = 32'h3C;
    tick();
    check("al.pc", 64'(pc_b), 64'h3C);
    bt_b = 1'b0;
    tick(); tick();
    check("al.h0_pc", 64'(opc_b), 64'h3C);
    check("al.h0_instr", 64'(oi_b), 64'hB000_000F);
    tick();
    check("al.h1_pc", 64'(opc_b), 64'h40);
    check("al.h1_instr", 64'(oi_b), 64'hB000_0000);
    check("al.mis", 64'(mis_b), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
